// File: rtl/rbfu_stage_sched_if.sv
// rbfu_stage_sched_if: control, issue and writeback signals between the RBFU stage scheduler and its controller
interface rbfu_stage_sched_if;
    logic       start;
    logic [1:0] mode;
    logic       issue_stall;
    logic       busy;
    logic [1:0] opcode;
    logic       radix_mode;
    logic       iss_valid;
    logic [6:0] iss_idx;
    logic [1:0] stage;
    logic [6:0] tw_idx;
    logic       wb_valid;
    logic [6:0] wb_idx;
    logic [1:0] wb_stage;
    logic       done;
    modport master (
        output start, mode, issue_stall,
        input  busy, opcode, radix_mode, iss_valid, iss_idx, stage, tw_idx,
        input  wb_valid, wb_idx, wb_stage, done
    );
    modport slave (
        input  start, mode, issue_stall,
        output busy, opcode, radix_mode, iss_valid, iss_idx, stage, tw_idx,
        output wb_valid, wb_idx, wb_stage, done
    );
endinterface

// File: rtl/rbfu_stage_sched.sv
// rbfu_stage_sched: stage walker and issue sequencer for the RBFU butterfly datapath (NTT/INTT/PWM)
module rbfu_stage_sched #(
    parameter int LAT_R2  = 2,
    parameter int LAT_R4  = 3,
    parameter int LAT_PWM = 3
) (
    input logic clk,
    input logic rst,
    rbfu_stage_sched_if.slave bus
);
    localparam int MAXL0 = LAT_R2 > LAT_R4 ? LAT_R2 : LAT_R4;
    localparam int MAXL  = MAXL0 > LAT_PWM ? MAXL0 : LAT_PWM;
    localparam int TW    = $clog2(MAXL);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic [1:0] opcode, opcode_n, stage, stage_n;
    logic [6:0] idx, idx_n, last_idx, tw;
    logic radix, iss, last_stage, wbv, last_wb;
    logic [TW-1:0] tap;
    logic [MAXL-1:0] p_v;
    logic [6:0] p_idx [MAXL];
    logic [1:0] p_stage [MAXL];
    assign radix      = opcode != 2'b11 && (opcode == 2'b10 || stage != 2'd3);
    assign iss        = state == ISSUE && !bus.issue_stall;
    assign last_idx   = opcode == 2'b10 ? 7'd127 : 7'd63;
    assign last_stage = opcode == 2'b10 || (opcode == 2'b00 ? stage == 2'd3 : stage == 2'd0);
    assign tap        = TW'((opcode == 2'b10 ? LAT_PWM : radix ? LAT_R4 : LAT_R2) - 1);
    // A longer tap after a radix switch can still see the previous stage's last entry; stage tag masks it
    assign wbv        = p_v[tap] && p_stage[tap] == stage;
    assign last_wb    = wbv && p_idx[tap] == last_idx;
    assign tw = opcode == 2'b11 ? 7'd0 :
                opcode == 2'b10 ? idx :
                !radix ? 7'd21 + idx :
                stage == 2'd0 ? 7'd0 :
                stage == 2'd1 ? 7'd1 + (idx >> 4) : 7'd5 + (idx >> 2);
    always_comb begin
        state_n  = state;
        opcode_n = opcode;
        stage_n  = stage;
        idx_n    = idx;
        case (state)
            IDLE: if (bus.start && bus.mode != 2'b11) begin
                state_n  = ISSUE;
                opcode_n = bus.mode;
                stage_n  = bus.mode == 2'b01 ? 2'd3 : 2'd0;
                idx_n    = '0;
            end
            ISSUE: if (iss) begin
                state_n = idx == last_idx ? DRAIN : ISSUE;
                idx_n   = idx == last_idx ? idx : idx + 7'd1;
            end
            DRAIN: if (last_wb) begin
                state_n  = last_stage ? DONE : ISSUE;
                opcode_n = last_stage ? 2'b11 : opcode;
                stage_n  = last_stage ? stage : opcode == 2'b00 ? stage + 2'd1 : stage - 2'd1;
                idx_n    = '0;
            end
            default: begin
                state_n = IDLE;
                stage_n = '0;
                idx_n   = '0;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            opcode <= 2'b11;
            stage  <= '0;
            idx    <= '0;
            p_v    <= '0;
            for (int i = 0; i < MAXL; i++) begin
                p_idx[i]   <= '0;
                p_stage[i] <= '0;
            end
        end else begin
            state      <= state_n;
            opcode     <= opcode_n;
            stage      <= stage_n;
            idx        <= idx_n;
            p_v        <= {p_v[MAXL-2:0], iss};
            p_idx[0]   <= idx;
            p_stage[0] <= stage;
            for (int i = 1; i < MAXL; i++) begin
                p_idx[i]   <= p_idx[i-1];
                p_stage[i] <= p_stage[i-1];
            end
        end
    end
    assign bus.busy       = state != IDLE;
    assign bus.opcode     = opcode;
    assign bus.radix_mode = radix;
    assign bus.iss_valid  = iss;
    assign bus.iss_idx    = idx;
    assign bus.stage      = stage;
    assign bus.tw_idx     = tw;
    assign bus.wb_valid   = wbv;
    assign bus.wb_idx     = p_idx[tap];
    assign bus.wb_stage   = p_stage[tap];
    assign bus.done       = state == DONE;
endmodule

// File: tb/tb_rbfu_stage_sched.sv
// tb_rbfu_stage_sched: table-driven transform runs checked by an issue/writeback scoreboard
module tb_rbfu_stage_sched;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    rbfu_stage_sched_if bus();
    rbfu_stage_sched #(.LAT_R2(2), .LAT_R4(3), .LAT_PWM(3)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        int st_from;
        int st_len;
        int st_idx;
        int rs_at;
        int exp_done;
        int exp_issues;
    } vec_t;
    typedef struct {
        int cyc;
        int lat;
        logic [1:0] stage;
        logic [6:0] idx;
        logic [6:0] tw;
        logic radix;
        logic [1:0] op;
    } iss_t;
    typedef struct {
        int due;
        logic [1:0] stage;
        logic [6:0] idx;
    } wb_t;
    iss_t expq[$];
    wb_t wbq[$];
    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, want);
        end
    endtask

    task automatic chk_reset(input string name);
        chk(name, 64'({bus.busy, bus.opcode, bus.radix_mode, bus.iss_valid, bus.iss_idx, bus.stage,
                       bus.tw_idx, bus.wb_valid, bus.wb_idx, bus.wb_stage, bus.done}),
                  64'({1'b0, 2'b11, 1'b0, 1'b0, 7'd0, 2'd0, 7'd0, 1'b0, 7'd0, 2'd0, 1'b0}));
    endtask

    // Expected issue stream: cycle relative to the start cycle, stall window shifts every later issue
    task automatic build(input vec_t v);
        int base[3] = '{0, 1, 5};
        int c = 1;
        int ns = v.mode == 2'b10 ? 1 : 4;
        int n = v.mode == 2'b10 ? 128 : 64;
        expq.delete();
        for (int j = 0; j < ns; j++) begin
            int st;
            int l;
            bit r4;
            st = v.mode == 2'b01 ? 3 - j : j;
            r4 = v.mode == 2'b10 || st != 3;
            l = v.mode == 2'b10 ? 3 : r4 ? 3 : 2;
            for (int i = 0; i < n; i++) begin
                iss_t e;
                e.cyc = c + i >= v.st_from ? c + i + v.st_len : c + i;
                e.lat = l;
                e.stage = 2'(st);
                e.idx = 7'(i);
                e.tw = v.mode == 2'b10 ? 7'(i) : !r4 ? 7'(21 + i) : 7'(base[st] + (i >> (6 - 2 * st)));
                e.radix = r4;
                e.op = v.mode;
                expq.push_back(e);
            end
            c += n + l;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int done_at = -1;
        int issues = 0;
        int dones = 0;
        iss_t e;
        wb_t w;
        logic [15:0] r;
        build(v);
        wbq.delete();
        @(posedge clk);
        #1;
        for (int rel = 0; rel < 700; rel++) begin
            if (rel > 0) begin
                @(posedge clk);
                #1;
            end
            bus.start = rel == 0 || rel == v.rs_at;
            bus.mode = rel == v.rs_at ? 2'b10 : v.mode;
            bus.issue_stall = rel >= v.st_from && rel < v.st_from + v.st_len;
            @(negedge clk);
            r = 16'(rel);
            if (rel == 1) chk("busy_on", 64'({bus.busy, bus.opcode}), 64'({1'b1, v.mode}));
            if (bus.issue_stall) chk("stall_hold", 64'({bus.iss_valid, bus.iss_idx}), 64'({1'b0, 7'(v.st_idx)}));
            while (wbq.size() > 0 && wbq[0].due < rel) begin
                w = wbq.pop_front();
                chk("wb_missing", 64'(rel), 64'(w.due));
            end
            if (bus.iss_valid) begin
                issues++;
                if (expq.size() == 0) chk("extra_issue", 64'(bus.iss_valid), 64'(0));
                else begin
                    e = expq.pop_front();
                    chk("issue", 64'({r, bus.stage, bus.iss_idx, bus.tw_idx, bus.radix_mode, bus.opcode}),
                                 64'({16'(e.cyc), e.stage, e.idx, e.tw, e.radix, e.op}));
                    w.due = e.cyc + e.lat;
                    w.stage = e.stage;
                    w.idx = e.idx;
                    wbq.push_back(w);
                end
            end
            if (bus.wb_valid) begin
                if (wbq.size() == 0) chk("extra_wb", 64'(bus.wb_valid), 64'(0));
                else begin
                    w = wbq.pop_front();
                    chk("wb", 64'({r, bus.wb_stage, bus.wb_idx}), 64'({16'(w.due), w.stage, w.idx}));
                end
            end
            if (bus.done) begin
                dones++;
                if (done_at < 0) done_at = rel;
            end
            if (done_at >= 0 && rel == done_at + 1) break;
        end
        bus.start = 1'b0;
        bus.issue_stall = 1'b0;
        chk("done_cycle", 64'(done_at), 64'(v.exp_done));
        chk("done_once", 64'(dones), 64'(1));
        chk("issue_count", 64'(issues), 64'(v.exp_issues));
        chk("post_done", 64'({bus.busy, bus.opcode, bus.done, bus.wb_valid}), 64'({1'b0, 2'b11, 1'b0, 1'b0}));
        chk("sb_empty", 64'(expq.size() + wbq.size()), 64'(0));
    endtask

    initial begin
        int quiet;
        vecs[0] = '{2'b00, 10000, 0, 0, -1, 268, 256};
        vecs[1] = '{2'b01, 10000, 0, 0, 30, 268, 256};
        vecs[2] = '{2'b10, 10000, 0, 0, -1, 132, 128};
        vecs[3] = '{2'b00, 11, 5, 10, -1, 273, 256};
        bus.start = 1'b0;
        bus.mode = 2'b00;
        bus.issue_stall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("reset_values");
        @(posedge clk);
        #1 rst = 1'b1;
        bus.start = 1'b1;
        bus.mode = 2'b11;
        @(posedge clk);
        #1 bus.start = 1'b0;
        bus.mode = 2'b00;
        repeat (2) begin
            @(negedge clk);
            chk("mode11_ignored", 64'({bus.busy, bus.opcode, bus.iss_valid}), 64'({1'b0, 2'b11, 1'b0}));
        end
        for (int k = 0; k < 4; k++) run_vec(vecs[k]);
        @(posedge clk);
        #1 bus.start = 1'b1;
        bus.mode = 2'b00;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (98) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_stage1", 64'({bus.busy, bus.stage, bus.iss_valid}), 64'({1'b1, 2'd1, 1'b1}));
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk_reset("reset_mid_transform");
        quiet = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.wb_valid || bus.done || bus.busy) quiet++;
        end
        chk("post_reset_quiet", 64'(quiet), 64'(0));
        run_vec(vecs[0]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
